// File: rtl/batting_pulse_multi.sv
// -----------------------------------------------------------------------------
// batting_pulse_multi
//
// Purpose:
//   Swing/result sequencer. A swing is armed by start. Once start drops, the
//   first valid result on hitout is latched into a registered one-hot pulse.
//   The pulse is held for PULSE_LEN cycles. The block then waits for every
//   result line to go quiet before it can be armed again. An optional timeout
//   abandons a swing that never resolves.
//
// Handshake:
//   There is no valid/ready pair. start is a level request that is sampled
//   only in IDLE. hitout is sampled only in ARMED, and only while start is
//   low, so a result that is still on the lines after the pulse cannot
//   re-trigger the block.
//
// Parameters:
//   NUM_RESULTS  number of result channels (2..16)
//   PULSE_LEN    cycles each result pulse is held (1..255)
//   TIMEOUT      ARMED cycles before the swing is abandoned; 0 disables it
//   MULTI_MODE   0: a multi-hot hitout is ignored; 1: the lowest set bit wins
//
// Ports:
//   clk            in   sole clock, rising edge
//   reset          in   asynchronous, active-high reset
//   start          in   swing request
//   hitout         in   [NUM_RESULTS] result lines (bit 0 = hit1, MSB = out)
//   pulse          out  [NUM_RESULTS] registered one-hot result pulse
//   result_idx     out  [4] index of the last accepted result
//   busy           out  high in every state except IDLE
//   timeout_pulse  out  single-cycle flag when a swing is abandoned
//   result_count   out  [8] saturating count of accepted results
//   o_state_dbg    out  [2] current FSM state (0 IDLE, 1 ARMED, 2 PULSE, 3 RELEASE)
// -----------------------------------------------------------------------------
module batting_pulse_multi #(
    parameter int NUM_RESULTS = 5,
    parameter int PULSE_LEN   = 1,
    parameter int TIMEOUT     = 0,
    parameter int MULTI_MODE  = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_RESULTS-1:0] hitout,
    output logic [NUM_RESULTS-1:0] pulse,
    output logic [3:0]             result_idx,
    output logic                   busy,
    output logic                   timeout_pulse,
    output logic [7:0]             result_count,
    output logic [1:0]             o_state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_PULSE   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    localparam logic [7:0]  PLEN_LAST  = 8'(PULSE_LEN - 1);
    localparam logic [15:0] TO_LAST    = 16'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam bit          TIMEOUT_EN = (TIMEOUT > 0);

    // Registered state and outputs
    state_t                 r_state;
    logic [NUM_RESULTS-1:0] r_pulse;
    logic [3:0]             r_result_idx;
    logic                   r_busy;
    logic                   r_timeout_pulse;
    logic [7:0]             r_result_count;
    logic [15:0]            r_tmr;     // ARMED cycle counter
    logic [7:0]             r_plen;    // cycles already spent in PULSE

    // Next-state values
    state_t                 w_state_next;
    logic [NUM_RESULTS-1:0] w_pulse_next;
    logic [3:0]             w_idx_next;
    logic                   w_tp_next;
    logic [7:0]             w_count_next;
    logic [15:0]            w_tmr_next;
    logic [7:0]             w_plen_next;

    // hitout decode
    logic [4:0]             w_popcnt;
    logic [3:0]             w_low_idx;
    logic                   w_valid;
    logic [NUM_RESULTS-1:0] w_onehot;

    // Scan from the MSB down so the last write leaves the lowest set index.
    always_comb begin
        w_popcnt  = '0;
        w_low_idx = '0;
        for (int i = NUM_RESULTS - 1; i >= 0; i--) begin
            w_popcnt = w_popcnt + 5'(hitout[i]);
            if (hitout[i]) begin
                w_low_idx = 4'(i);
            end
        end
    end

    // In mode 0 a multi-hot pattern is not a result. In mode 1 any non-zero
    // pattern is a result, and the lowest set bit is the one reported.
    assign w_valid  = (MULTI_MODE != 0) ? (hitout != '0) : (w_popcnt == 5'd1);
    assign w_onehot = {{(NUM_RESULTS-1){1'b0}}, 1'b1} << w_low_idx;

    // Next-state and next-output logic
    always_comb begin
        w_state_next = r_state;
        w_pulse_next = '0;
        w_idx_next   = r_result_idx;
        w_tp_next    = 1'b0;
        w_count_next = r_result_count;
        w_tmr_next   = r_tmr;
        w_plen_next  = r_plen;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_ARMED;
                    w_tmr_next   = '0;
                end
            end

            S_ARMED: begin
                // A result on the expiry cycle takes priority over the timeout.
                if (!start && w_valid) begin
                    w_state_next = S_PULSE;
                    w_pulse_next = w_onehot;
                    w_idx_next   = w_low_idx;
                    w_plen_next  = '0;
                    if (r_result_count != 8'hFF) begin
                        w_count_next = r_result_count + 8'd1;
                    end
                end else if (TIMEOUT_EN && (r_tmr == TO_LAST)) begin
                    w_state_next = S_IDLE;
                    w_tp_next    = 1'b1;
                    w_tmr_next   = '0;
                end else if (TIMEOUT_EN) begin
                    w_tmr_next = r_tmr + 16'd1;
                end
            end

            S_PULSE: begin
                if (r_plen == PLEN_LAST) begin
                    w_state_next = S_RELEASE;
                end else begin
                    w_pulse_next = r_pulse;
                    w_plen_next  = r_plen + 8'd1;
                end
            end

            S_RELEASE: begin
                // Wait for the result lines to clear so that a held line
                // cannot fire a second pulse.
                if (hitout == '0) begin
                    w_state_next = S_IDLE;
                end
            end

            default: begin
                w_state_next = S_IDLE;
                w_idx_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= S_IDLE;
            r_pulse         <= '0;
            r_result_idx    <= '0;
            r_busy          <= 1'b0;
            r_timeout_pulse <= 1'b0;
            r_result_count  <= '0;
            r_tmr           <= '0;
            r_plen          <= '0;
        end else begin
            r_state         <= w_state_next;
            r_pulse         <= w_pulse_next;
            r_result_idx    <= w_idx_next;
            r_busy          <= (w_state_next != S_IDLE);
            r_timeout_pulse <= w_tp_next;
            r_result_count  <= w_count_next;
            r_tmr           <= w_tmr_next;
            r_plen          <= w_plen_next;
        end
    end

    assign pulse         = r_pulse;
    assign result_idx    = r_result_idx;
    assign busy          = r_busy;
    assign timeout_pulse = r_timeout_pulse;
    assign result_count  = r_result_count;
    assign o_state_dbg   = r_state;

endmodule

// File: doc/batting_pulse_multi.md
BATTING_PULSE_MULTI -- requirements
Module: batting_pulse_multi

Interface
REQ-001 Parameter NUM_RESULTS, default 5, number of result channels (hit1..hit4, out); legal 2..16.
REQ-002 Parameter PULSE_LEN, default 1, cycles each result pulse is held high; legal 1..255.
REQ-003 Parameter TIMEOUT, default 0, ARMED cycles before abandoning a swing; 0 disables timeout; legal 0..65535.
REQ-004 Parameter MULTI_MODE, default 0: 0 = multi-hot hitout ignored, 1 = lowest asserted index wins.
REQ-005 clk  input  1  sole clock, all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  swing request; high arms the block, must fall before a result is accepted.
REQ-008 hitout  input  NUM_RESULTS  result lines, bit 0 = hit1, bit NUM_RESULTS-1 = out.
REQ-009 pulse  output  NUM_RESULTS  registered one-hot result pulse.
REQ-010 result_idx  output  4  index of the last accepted result, registered.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 timeout_pulse  output  1  single-cycle flag on swing abandonment.
REQ-013 result_count  output  8  saturating count of accepted results.

Function
REQ-014 States SHALL be IDLE, ARMED, PULSE, RELEASE.
REQ-015 IDLE: start=1 -> ARMED next cycle; else remain IDLE.
REQ-016 ARMED: a result is accepted only when start=0 and hitout is valid per REQ-017.
REQ-017 Valid hitout: exactly one bit set; with MULTI_MODE=1 any non-zero value, lowest set bit selected; with MULTI_MODE=0 multi-hot is treated as no result.
REQ-018 Accepted result at edge N: state -> PULSE, pulse[k]=1 and result_idx=k visible after edge N, held for exactly PULSE_LEN cycles.
REQ-019 Only one pulse bit SHALL be high at any time; pulse SHALL be all-zero outside PULSE.
REQ-020 result_count SHALL increment by 1 on each accepted result, saturating at 255 without wrap.
REQ-021 ARMED with start=1 or no valid hitout: remain ARMED; timeout counter advances.
REQ-022 TIMEOUT>0: after TIMEOUT consecutive ARMED cycles without acceptance, timeout_pulse=1 for one cycle and state -> IDLE; result_count unchanged.
REQ-023 A valid result on the same cycle the timeout expires SHALL win; no timeout_pulse.
REQ-024 Timeout counter SHALL clear on every ARMED entry.
REQ-025 After PULSE_LEN cycles, PULSE -> RELEASE; RELEASE -> IDLE on the first cycle hitout==0, else remain (prevents re-trigger from a held result line).
REQ-026 start is ignored in PULSE and RELEASE; a new swing requires start observed in IDLE.
REQ-027 Illegal/unused state encodings SHALL return to IDLE next cycle with outputs zero.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 reset=1 SHALL immediately force state=IDLE, pulse=0, result_idx=0, busy=0, timeout_pulse=0, result_count=0, timers=0, independent of clk.
REQ-030 Reset asserted mid-PULSE SHALL truncate the pulse at once; no pulse resumes after release.
REQ-031 First state change after reset deassertion SHALL occur on the first rising edge with reset=0.

Verification
REQ-032 Defaults: start=1 for 1 cycle, start=0 with hitout=5'b00100 -> pulse=5'b00100 for 1 cycle, result_idx=2, result_count=1, busy falls after hitout returns to 0.
REQ-033 PULSE_LEN=3: hitout=5'b00001 accepted -> pulse=5'b00001 high exactly 3 cycles; holding hitout 10 cycles keeps state RELEASE with pulse=0 and no second pulse.
REQ-034 MULTI_MODE=0 vs 1: hitout=5'b10110 in ARMED -> mode 0 stays ARMED, pulse=0; mode 1 pulse=5'b00010, result_idx=1.
REQ-035 TIMEOUT=4: arm, hitout=0 -> timeout_pulse high one cycle on the 4th ARMED cycle, state IDLE, result_count unchanged; valid hit on that cycle -> pulse, no timeout_pulse.
REQ-036 256 accepted results -> result_count=255 (no wrap to 0).
REQ-037 reset asserted between clk edges during PULSE_LEN=5 pulse -> pulse, busy, result_count 0 immediately; after release, hitout alone produces no pulse until start.
